datamemory_hs: RTL and testbench

- Parametrised, handshaked successor to the single-cycle RV32I data memory.
- Owns a byte-lane RAM. Accepts one load/store request at a time over valid/ready. Returns a response (load data or store ack) after a configurable read latency, held until the consumer accepts it.
- Adds LHU, misalignment and illegal-funct3 fault reporting, and response back-pressure.
- Sits between the MEM-stage/LSU and storage; the core stalls on req_ready / rsp_valid.

---
 rtl/dmem_pkg.sv | 57 +++++
 rtl/dmem_bank.sv | 34 +++
 rtl/datamemory_hs.sv | 124 ++++++++++++
 tb/tb_datamemory_hs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the handshaked data memory
// Purpose: funct3 encodings, FSM state type, byte-enable / load-extend /
//          alignment helpers used by datamemory_hs.
// Ports:   none (package).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} dmem_state_t;

  // Lane mask for a store of the given size at byte offset off.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B:    byte_en = 4'b0001 << off;
      F3_H:    byte_en = 4'b0011 << {off[1], 1'b0};
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Select the addressed lane(s) from a RAM word and sign/zero extend.
  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_ext = {{16{sh[15]}}, sh[15:0]};
      F3_W:    load_ext = word;
      F3_BU:   load_ext = {24'd0, sh[7:0]};
      F3_HU:   load_ext = {16'd0, sh[15:0]};
      default: load_ext = 32'd0;
    endcase
  endfunction

  // funct3[1:0] encodes the access size for every legal load/store.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we)
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-lane RAM with one synchronous word port
// Purpose: NBYTES independent 8-bit lanes, per-lane write enable,
//          registered read output updated only when i_re is high.
// Ports:   clk; i_addr word index; i_we per-lane write enable; i_wdata write
//          word; i_re read strobe; o_rdata registered read word.
module dmem_bank #(
  parameter int AW     = 7,
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic [AW-1:0]         i_addr,
  input  logic [NBYTES-1:0]     i_we,
  input  logic [8*NBYTES-1:0]   i_wdata,
  input  logic                  i_re,
  output logic [8*NBYTES-1:0]   o_rdata
);

  localparam int DEPTH = 2 ** AW;

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we[g])
        r_mem[i_addr] <= i_wdata[8*g +: 8];
      if (i_re)
        r_q <= r_mem[i_addr];
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/datamemory_hs.sv
// rtl/datamemory_hs.sv - handshaked RV32I data memory
// Purpose: accepts one load/store at a time over valid/ready, returns load
//          data or a store ack after LAT_RD (loads) / 1 (stores, faults)
//          cycles, held until rsp_ready.
// Ports:   clk, reset (sync, active high); req_valid/req_ready/req_we/
//          req_funct3/req_addr/req_wdata request channel; rsp_valid/
//          rsp_ready/rsp_rdata/rsp_fault response channel.
module datamemory_hs
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LAT_RD     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_fault
);

  localparam int NBYTES = DATA_W / 8;
  localparam int WA     = DM_ADDRESS - 2;

  dmem_state_t       r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_fault;
  logic              r_is_load;

  logic              w_accept;
  logic              w_fault;
  logic [NBYTES-1:0] w_be;
  logic              w_re;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready && !reset;
  assign w_fault   = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

  // RAM is touched only on a clean accepted request; faults never write.
  assign w_be = (w_accept && req_we && !w_fault) ? byte_en(req_funct3, req_addr[1:0])
                                                 : '0;
  assign w_re = w_accept && !req_we && !w_fault;

  always_comb begin
    w_wdata = req_wdata;
    case (req_funct3)
      F3_B:    w_wdata = {NBYTES{req_wdata[7:0]}};
      F3_H:    w_wdata = {(NBYTES/2){req_wdata[15:0]}};
      default: w_wdata = req_wdata;
    endcase
  end

  dmem_bank #(
    .AW     (WA),
    .NBYTES (NBYTES)
  ) u_bank (
    .clk     (clk),
    .i_addr  (req_addr[DM_ADDRESS-1:2]),
    .i_we    (w_be),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
      r_fault   <= 1'b0;
      r_is_load <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_f3      <= req_funct3;
            r_off     <= req_addr[1:0];
            r_fault   <= w_fault;
            r_is_load <= !req_we && !w_fault;
            if (!req_we && !w_fault && (LAT_RD > 1)) begin
              r_state <= RD_WAIT;
              r_cnt   <= 3'(LAT_RD - 1);
            end else begin
              r_state <= RESP;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == 3'd1) begin
            r_state <= RESP;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The bank read register only updates on an accepted load, which cannot
  // happen outside IDLE, so the response stays stable while stalled.
  assign rsp_valid = (r_state == RESP);
  assign rsp_fault = (r_state == RESP) && r_fault;
  assign rsp_rdata = ((r_state == RESP) && r_is_load) ? load_ext(r_f3, r_off, w_rdata)
                                                      : '0;

endmodule

// File: tb/tb_datamemory_hs.sv
// tb/tb_datamemory_hs.sv - self-checking bench for datamemory_hs
module tb_datamemory_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_fault1;
  logic [31:0] rsp_rdata1;
  logic        req_ready3, rsp_valid3, rsp_fault3;
  logic [31:0] rsp_rdata3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datamemory_hs #(.DM_ADDRESS(9), .DATA_W(32), .LAT_RD(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_fault(rsp_fault1)
  );

  datamemory_hs #(.DM_ADDRESS(9), .DATA_W(32), .LAT_RD(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata3), .rsp_fault(rsp_fault3)
  );

  // Byte-addressed reference memory.
  logic [7:0] mem [0:511];

  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [8:0] a);
    int sz;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
    return !legal || ((int'(a) % sz) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] a);
    int i;
    logic [15:0] h;
    i = int'(a);
    case (f3)
      3'd0: return {{24{mem[i][7]}}, mem[i]};
      3'd4: return {24'd0, mem[i]};
      3'd1: begin h = {mem[i+1], mem[i]}; return {{16{h[15]}}, h}; end
      3'd5: begin h = {mem[i+1], mem[i]}; return {16'd0, h}; end
      3'd2: return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    int i;
    i = int'(a);
    mem[i] = wd[7:0];
    if (f3 != 3'd0) mem[i+1] = wd[15:8];
    if (f3 == 3'd2) begin mem[i+2] = wd[23:16]; mem[i+3] = wd[31:24]; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One request to both instances; waits for both responses, stalls, releases.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [8:0] a,
                     input logic [31:0] wd, input int stall,
                     output logic [31:0] rd1, output logic f1, output int l1,
                     output logic [31:0] rd3, output logic f3o, output int l3);
    rd1 = '0; f1 = 1'b0; l1 = 0; rd3 = '0; f3o = 1'b0; l3 = 0;
    @(negedge clk);
    chk("req_ready1 idle", 32'(req_ready1), 32'd1);
    chk("req_ready3 idle", 32'(req_ready3), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int c = 1; c <= 20 && (l1 == 0 || l3 == 0); c++) begin
      @(negedge clk);
      if (rsp_valid1 && l1 == 0) begin l1 = c; rd1 = rsp_rdata1; f1 = rsp_fault1; end
      if (rsp_valid3 && l3 == 0) begin l3 = c; rd3 = rsp_rdata3; f3o = rsp_fault3; end
    end
    if (l1 == 0 || l3 == 0) begin
      n_checks++; n_errors++;
      $display("FAIL rsp timeout: lat1=%0d lat3=%0d required nonzero", l1, l3);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall rdata1 stable", rsp_rdata1, rd1);
      chk("stall rdata3 stable", rsp_rdata3, rd3);
      chk("stall valid3", 32'(rsp_valid3), 32'd1);
      chk("stall req_ready3", 32'(req_ready3), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post rsp valid1", 32'(rsp_valid1), 32'd0);
    chk("post rsp req_ready3", 32'(req_ready3), 32'd1);
  endtask

  // Runs a request, compares both instances against expectations.
  task automatic run_check(input string name, input logic we, input logic [2:0] f3,
                           input logic [8:0] a, input logic [31:0] wd, input int stall,
                           input logic [31:0] exp_rd, input logic exp_f);
    logic [31:0] rd1, rd3;
    logic f1, f3o;
    int l1, l3;
    txn(we, f3, a, wd, stall, rd1, f1, l1, rd3, f3o, l3);
    chk({name, " rdata1"}, rd1, exp_rd);
    chk({name, " rdata3"}, rd3, exp_rd);
    chk({name, " fault1"}, 32'(f1), 32'(exp_f));
    chk({name, " fault3"}, 32'(f3o), 32'(exp_f));
    chk({name, " lat1"}, 32'(l1), 32'd1);
    chk({name, " lat3"}, 32'(l3), (we || exp_f) ? 32'd1 : 32'd3);
    if (we && !exp_f) m_store(f3, a, wd);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid1", 32'(rsp_valid1), 32'd0);
    chk("reset rsp_valid3", 32'(rsp_valid3), 32'd0);
    chk("reset rsp_rdata1", rsp_rdata1, 32'd0);
    chk("reset rsp_fault3", 32'(rsp_fault3), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after reset req_ready1", 32'(req_ready1), 32'd1);
    chk("after reset req_ready3", 32'(req_ready3), 32'd1);

    // rsp_ready while idle must not disturb anything.
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle rsp_ready valid1", 32'(rsp_valid1), 32'd0);
    chk("idle rsp_ready req_ready3", 32'(req_ready3), 32'd1);
    rsp_ready = 1'b0;

    // Fill every word with known data.
    for (int w = 0; w < 128; w++)
      run_check("init SW", 1'b1, 3'd2, 9'(w * 4), $urandom, 0, 32'd0, 1'b0);

    tbl.push_back('{"SW 10",     1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{"LW 10",     1'b0, 3'd2, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{"SB 13",     1'b1, 3'd0, 9'h013, 32'h00000080, 32'h0,        1'b0});
    tbl.push_back('{"LB 13",     1'b0, 3'd0, 9'h013, 32'h0,        32'hFFFFFF80, 1'b0});
    tbl.push_back('{"LBU 13",    1'b0, 3'd4, 9'h013, 32'h0,        32'h00000080, 1'b0});
    tbl.push_back('{"LW 10 b",   1'b0, 3'd2, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0});
    tbl.push_back('{"SW 20",     1'b1, 3'd2, 9'h020, 32'h12345678, 32'h0,        1'b0});
    tbl.push_back('{"SH 22",     1'b1, 3'd1, 9'h022, 32'h00008001, 32'h0,        1'b0});
    tbl.push_back('{"LH 22",     1'b0, 3'd1, 9'h022, 32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{"LHU 22",    1'b0, 3'd5, 9'h022, 32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{"LW 20",     1'b0, 3'd2, 9'h020, 32'h0,        32'h80015678, 1'b0});
    tbl.push_back('{"LW 11 mis", 1'b0, 3'd2, 9'h011, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{"SH 21 mis", 1'b1, 3'd1, 9'h021, 32'h0000FFFF, 32'h0,        1'b1});
    tbl.push_back('{"L f3=011",  1'b0, 3'd3, 9'h010, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{"S f3=100",  1'b1, 3'd4, 9'h020, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{"LW 10 c",   1'b0, 3'd2, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0});
    tbl.push_back('{"LW 20 c",   1'b0, 3'd2, 9'h020, 32'h0,        32'h80015678, 1'b0});
    tbl.push_back('{"SW top",    1'b1, 3'd2, 9'h1FC, 32'hA5C3E781, 32'h0,        1'b0});
    tbl.push_back('{"LW top",    1'b0, 3'd2, 9'h1FC, 32'h0,        32'hA5C3E781, 1'b0});
    tbl.push_back('{"LB 1FF",    1'b0, 3'd0, 9'h1FF, 32'h0,        32'hFFFFFFA5, 1'b0});
    tbl.push_back('{"LHU 1FE",   1'b0, 3'd5, 9'h1FE, 32'h0,        32'h0000A5C3, 1'b0});

    foreach (tbl[i])
      run_check(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, 1,
                tbl[i].exp_rd, tbl[i].exp_f);

    // Long stall on a LAT_RD=3 load.
    run_check("LW stall5", 1'b0, 3'd2, 9'h010, 32'h0, 5, m_load(3'd2, 9'h010), 1'b0);

    // Reset while dut3 sits in RD_WAIT (dut1 is already in RESP).
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 9'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst in wait req_ready1", 32'(req_ready1), 32'd1);
    chk("rst in wait req_ready3", 32'(req_ready3), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst discard valid1", 32'(rsp_valid1), 32'd0);
      chk("rst discard valid3", 32'(rsp_valid3), 32'd0);
    end
    run_check("LW after rst", 1'b0, 3'd2, 9'h010, 32'h0, 0, m_load(3'd2, 9'h010), 1'b0);

    // A store presented during reset must not write.
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h020;
    req_wdata = 32'h0BADF00D;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    run_check("LW no rst write", 1'b0, 3'd2, 9'h020, 32'h0, 0, m_load(3'd2, 9'h020), 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [8:0]  a;
      logic [31:0] wd;
      logic        f;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 2) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 1) != 0) a[1] = 1'b0;
      wd = $urandom;
      f  = m_fault(we, f3, a);
      run_check("rand", we, f3, a, wd, $urandom_range(0, 3),
                (f || we) ? 32'd0 : m_load(f3, a), f);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
